// File: rtl/key_event_pkg.sv
// key_event_pkg
// Shared definitions for the button front end.
//   state_t        : classifier state encoding (code 3 is unused and
//                    decodes to IDLE)
//   TICK_DIV_BOARD : 1 ms prescaler terminal count at 50 MHz
//   TICK_DIV_SIM   : shortened terminal count for simulation
// Both TICK_DIV values are shared with the debouncer.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned TICK_DIV_BOARD = 49999;
  localparam int unsigned TICK_DIV_SIM   = 49;

endpackage

// File: rtl/key_event_ms_tick.sv
// ms_tick
// Free-running millisecond prescaler. Emits one tick every TICK_DIV+1
// clocks.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous reset, active-low
//   tick out high for the one clk in which the counter sits at TICK_DIV
module ms_tick #(
  parameter int unsigned TICK_DIV = 49999
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [15:0] TC = 16'(TICK_DIV);

  logic [15:0] cnt;

  assign tick = (cnt == TC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/key_event.sv
// key_event
// Turns the debounced key level into single-cycle event pulses for the
// watch mode/set state machines.
// Ports:
//   clk        in  system clock, rising edge
//   rst        in  asynchronous reset, active-low
//   key        in  debounced button level, 1 = pressed
//   press_pls  out one-clk pulse on press
//   short_pls  out one-clk pulse on release before the long threshold
//   long_pls   out one-clk pulse when the hold reaches LONG_MS ticks
//   rpt_pls    out one-clk pulse every RPT_MS ticks after long_pls
//   rel_pls    out one-clk pulse on every release that ends a press
//   held       out high while in HOLD
// All outputs are registered.
module key_event
  import key_event_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_BOARD,
  parameter int unsigned LONG_MS  = 1000,
  parameter int unsigned RPT_MS   = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press_pls,
  output logic short_pls,
  output logic long_pls,
  output logic rpt_pls,
  output logic rel_pls,
  output logic held
);

  localparam logic [15:0] LONG_TC = 16'(LONG_MS - 1);
  localparam logic [15:0] RPT_TC  = 16'(RPT_MS - 1);

  state_t      state;
  logic        key_d;
  logic [15:0] hold_cnt;
  logic [15:0] rpt_cnt;
  logic        tick;
  logic        rise;
  logic        fall;

  ms_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_ms_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign rise = key & ~key_d;
  assign fall = ~key & key_d;

  // key_d resets to 1 so a key held through reset must be released and
  // pressed again before it produces any event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      key_d     <= 1'b1;
      hold_cnt  <= '0;
      rpt_cnt   <= '0;
      press_pls <= 1'b0;
      short_pls <= 1'b0;
      long_pls  <= 1'b0;
      rpt_pls   <= 1'b0;
      rel_pls   <= 1'b0;
      held      <= 1'b0;
    end else begin
      key_d     <= key;
      press_pls <= 1'b0;
      short_pls <= 1'b0;
      long_pls  <= 1'b0;
      rpt_pls   <= 1'b0;
      rel_pls   <= 1'b0;

      case (state)
        PRESS: begin
          // A release beats a same-cycle threshold tick: short, never long.
          if (fall) begin
            state     <= IDLE;
            short_pls <= 1'b1;
            rel_pls   <= 1'b1;
          end else if (tick) begin
            hold_cnt <= hold_cnt + 16'd1;
            if (hold_cnt == LONG_TC) begin
              state    <= HOLD;
              long_pls <= 1'b1;
              held     <= 1'b1;
              rpt_cnt  <= '0;
            end
          end
        end

        HOLD: begin
          // No repeat pulse in the release cycle.
          if (fall) begin
            state   <= IDLE;
            rel_pls <= 1'b1;
            held    <= 1'b0;
          end else if (tick) begin
            if (rpt_cnt == RPT_TC) begin
              rpt_pls <= 1'b1;
              rpt_cnt <= '0;
            end else begin
              rpt_cnt <= rpt_cnt + 16'd1;
            end
          end
        end

        default: begin
          // IDLE and the unused code 3; a fall here is ignored.
          state <= IDLE;
          held  <= 1'b0;
          if (rise) begin
            state     <= PRESS;
            hold_cnt  <= '0;
            press_pls <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event.sv
module tb_key_event;

  logic clk;
  logic rst;
  logic key;
  logic press_pls;
  logic short_pls;
  logic long_pls;
  logic rpt_pls;
  logic rel_pls;
  logic held;

  key_event #(
    .TICK_DIV(49),
    .LONG_MS (10),
    .RPT_MS  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .press_pls(press_pls),
    .short_pls(short_pls),
    .long_pls (long_pls),
    .rpt_pls  (rpt_pls),
    .rel_pls  (rel_pls),
    .held     (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse bookkeeping: index 0 press, 1 short, 2 long, 3 rpt, 4 rel.
  int n_vec;
  int n_err;
  int k;           // posedge index since the last reset release
  int pn[5];       // pulse counts
  int fk[5];       // edge index of first pulse
  int lk[5];       // edge index of last pulse
  int viol;        // exclusivity violations
  logic held_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int j = 0; j < 5; j++) begin
      pn[j] = 0;
      fk[j] = -1;
      lk[j] = -1;
    end
    held_seen = 1'b0;
  endtask

  // Advance cyc clocks, sampling outputs 1 time unit after each edge.
  task automatic run(input int cyc);
    logic [4:0] p;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk);
      k++;
      #1;
      p = {rel_pls, rpt_pls, long_pls, short_pls, press_pls};
      for (int j = 0; j < 5; j++) begin
        if (p[j]) begin
          if (pn[j] == 0) fk[j] = k;
          lk[j] = k;
          pn[j]++;
        end
      end
      if (held) held_seen = 1'b1;
      if ((int'(short_pls) + int'(long_pls) + int'(rpt_pls)) > 1) viol++;
      if (rel_pls && (long_pls || rpt_pls)) viol++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    viol  = 0;
    k     = -1;
    rst   = 1'b0;
    key   = 1'b0;
    clear_counts();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {26'd0, press_pls, short_pls, long_pls, rpt_pls, rel_pls, held}, 32'd0);
    rst = 1'b1;
    k   = -1;

    // Idle: 2000 clocks with key low, edges 0..1999
    run(2000);
    check("idle_pulses", pn[0] + pn[1] + pn[2] + pn[3] + pn[4], 0);
    check("idle_held", {31'd0, held_seen}, 32'd0);

    // Short press: rise sampled at edge 2000, fall at 2250 (5 ticks held)
    clear_counts();
    key = 1'b1;
    run(250);
    key = 1'b0;
    run(10);
    check("short_press_n", pn[0], 1);
    check("short_press_k", fk[0], 2000);
    check("short_short_n", pn[1], 1);
    check("short_short_k", fk[1], 2250);
    check("short_rel_k", fk[4], 2250);
    check("short_long_n", pn[2], 0);

    // Long hold: rise at 2260, ticks at 2299+50n; long on 10th tick (2749),
    // repeats at ticks 14 and 18 (2949, 3149), release sampled at 3260
    clear_counts();
    key = 1'b1;
    run(489);
    check("long_pre_held", {31'd0, held}, 32'd0);
    check("long_pre_n", pn[2], 0);
    run(1);
    check("long_k", lk[2], 2749);
    check("long_held_rise", {31'd0, held}, 32'd1);
    run(510);
    check("long_held_mid", {31'd0, held}, 32'd1);
    check("rpt_n", pn[3], 2);
    check("rpt_first_k", fk[3], 2949);
    check("rpt_last_k", lk[3], 3149);
    key = 1'b0;
    run(1);
    check("long_rel_k", lk[4], 3260);
    check("long_held_fall", {31'd0, held}, 32'd0);
    run(9);
    check("long_press_k", fk[0], 2260);
    check("long_short_n", pn[1], 0);
    check("long_rel_n", pn[4], 1);

    // Fall coincides with the 10th tick: rise at 3270, 10th tick at 3749
    clear_counts();
    key = 1'b1;
    run(479);
    key = 1'b0;
    run(11);
    check("tie_short_k", fk[1], 3749);
    check("tie_rel_k", fk[4], 3749);
    check("tie_long_n", pn[2], 0);
    check("tie_held", {31'd0, held_seen}, 32'd0);

    // Reset during HOLD: rise at 3760, long at 4249
    clear_counts();
    key = 1'b1;
    run(500);
    check("rst_pre_held", {31'd0, held}, 32'd1);
    rst = 1'b0;
    #2;
    check("rst_async_outputs",
          {26'd0, press_pls, short_pls, long_pls, rpt_pls, rel_pls, held}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    k   = -1;
    clear_counts();
    run(200);
    check("rst_held_key_press_n", pn[0], 0);
    check("rst_held_key_long_n", pn[2], 0);
    key = 1'b0;
    run(5);
    check("rst_idle_fall_rel_n", pn[4], 0);
    key = 1'b1;
    run(1);
    check("rst_repress_k", lk[0], 205);

    // Back-to-back: release, then key 1,0,1,0 one clock each
    key = 1'b0;
    run(5);
    clear_counts();
    key = 1'b1;
    run(1);
    key = 1'b0;
    run(1);
    key = 1'b1;
    run(1);
    key = 1'b0;
    run(3);
    check("b2b_press_n", pn[0], 2);
    check("b2b_press_first_k", fk[0], 211);
    check("b2b_short_first_k", fk[1], 212);
    check("b2b_rel_first_k", fk[4], 212);
    check("b2b_press_last_k", lk[0], 213);
    check("b2b_short_last_k", lk[1], 214);

    check("pulse_exclusivity", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_event.md
# key_event

Button-event classifier that sits directly downstream of the debouncer in the watch front end. It consumes the debouncer's clean, active-high `key` level and turns each press into single-cycle event pulses: press, short release, long-press, auto-repeat while held, and release. The mode/set state machines of the watch consume these pulses instead of raw levels.

## Interface
- `TICK_DIV`, 49999: prescaler terminal count. One ms tick every TICK_DIV+1 clocks. Board 49999 at 50 MHz; simulation 49.
- `LONG_MS`, 1000: hold time in ticks before `long_pls`. Range 1..65535.
- `RPT_MS`, 200: auto-repeat period in ticks after `long_pls`. Range 1..65535.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `key`  in  1  debounced button level, 1 = pressed; synchronous to `clk`.
- `press_pls`  out  1  one-clk pulse on press.
- `short_pls`  out  1  one-clk pulse on release before the long threshold.
- `long_pls`  out  1  one-clk pulse when the hold reaches `LONG_MS`.
- `rpt_pls`  out  1  one-clk pulse every `RPT_MS` ticks after `long_pls` while held.
- `rel_pls`  out  1  one-clk pulse on every release that ends a press.
- `held`  out  1  level, high while in HOLD state.

## Operation
- Reset (`rst`=0): state IDLE, all outputs 0, counters 0, `key_d`=1.
- `key_d` register: rise = `key` & ~`key_d`; fall = ~`key` & `key_d`.
- Because `key_d` resets to 1, a key held through reset release produces no event until it is released and pressed again.
- Tick: free-running 16-bit `cnt`. When `cnt`==TICK_DIV: `tick`=1 for that clk and `cnt`<=0; otherwise `cnt`+1.
- IDLE:
  - rise -> PRESS, `hold_cnt`<=0, `press_pls`.
  - fall is ignored.
- PRESS:
  - On tick, `hold_cnt`+1.
  - fall -> IDLE with `short_pls` and `rel_pls`.
  - Else, tick with `hold_cnt`==LONG_MS-1 -> HOLD, `long_pls`, `rpt_cnt`<=0.
- HOLD (`held`=1):
  - On tick, `rpt_cnt`+1.
  - On tick with `rpt_cnt`==RPT_MS-1: `rpt_pls` and `rpt_cnt`<=0.
  - fall -> IDLE with `rel_pls` only; no short, no repeat.
- Simultaneous events: fall wins over a same-cycle threshold tick. PRESS gives short, never long. HOLD gives no `rpt_pls` in the release cycle.
- Counters are 16 bits and never wrap in practice, because the thresholds terminate counting.
- The tick phase is not realigned on press, so long/repeat timing has +0/-1 tick jitter.
- At most one of `short_pls`/`long_pls`/`rpt_pls` is high in any clk; `rel_pls` coincides only with `short_pls`, or alone.

## Timing
- All outputs are registered.
- A pulse is high for exactly the one clk following the edge at which its condition was sampled.
- Latency from `key` change to pulse: 1 clk.
- `long_pls` is asserted on the LONG_MS-th tick after entry to PRESS.
- First `rpt_pls` comes RPT_MS ticks after `long_pls`, then every RPT_MS ticks.
- `held` rises with `long_pls` and falls with `rel_pls`.
- Reset asserted mid-press: outputs drop to 0 asynchronously. After release, the rule for a key held through reset applies.

## Structure
- Shared package holds:
  - state encoding IDLE=2'd0, PRESS=2'd1, HOLD=2'd2; code 3 decodes to IDLE;
  - board/sim `TICK_DIV` values 49999/49, shared with the debouncer.
- Sub-module `ms_tick` (parameter `TICK_DIV`; ports `clk`, `rst`, `tick`) holds the prescaler.
- FSM, counters and edge detect live in `key_event`.

## Test plan
Bench parameters: TICK_DIV=49, LONG_MS=10, RPT_MS=4.
- Idle, `key`=0 for 2000 clk -> no pulse; `held`=0.
- `key` high 5 ticks (250 clk), then low -> one `press_pls`; one `short_pls`+`rel_pls` in the same clk 1 clk after the fall; no `long_pls`.
- `key` high 20 ticks -> `press_pls`; `long_pls` at tick 10; `rpt_pls` at ticks 14 and 18; `held` high ticks 10–20; release gives `rel_pls` only.
- `key` falls in the same clk as the 10th tick -> `short_pls`+`rel_pls`; no `long_pls`; `held` stays 0.
- `rst` low during HOLD while `key`=1 -> all outputs 0 immediately. After `rst` returns high with `key` still 1 -> no `press_pls`. Then `key` 0 -> 1 -> `press_pls`.
- Back-to-back presses 1 clk apart (`key` 1, 0, 1) -> `press_pls`, `short_pls`+`rel_pls`, `press_pls` on consecutive edges.
